// File: rtl/vram_blitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vram_blitter
// Brief    : Rectangle FILL / XOR engine on the VRAM system port; stalls on
//            vram_busy and pulses blt_done when the rectangle is finished.
// Revision : 1.0 - initial release
// ============================================================================
module vram_blitter #(
    parameter int ROW_WORDS = 32,
    parameter int ROWS      = 256,
    parameter int ADDR_W    = 13
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         blt_start,
    input  logic                         blt_mode,
    input  logic [$clog2(ROW_WORDS)-1:0] blt_col0,
    input  logic [$clog2(ROW_WORDS)-1:0] blt_col1,
    input  logic [$clog2(ROWS)-1:0]      blt_row0,
    input  logic [$clog2(ROWS)-1:0]      blt_row1,
    input  logic [15:0]                  blt_pattern,
    output logic                         blt_busy,
    output logic                         blt_done,
    output logic                         vram_load,
    output logic [ADDR_W-1:0]            vram_addr,
    output logic [15:0]                  vram_din,
    input  logic                         vram_busy,
    input  logic [15:0]                  vram_dout
);

    localparam int COL_W = $clog2(ROW_WORDS);
    localparam int ROW_W = $clog2(ROWS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_CAP   = 3'd2,
        ST_WR    = 3'd3,
        ST_EMPTY = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_mode;
    logic [COL_W-1:0]   r_col0;
    logic [COL_W-1:0]   r_col1;
    logic [ROW_W-1:0]   r_row1;
    logic [15:0]        r_pattern;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   w_col_nxt;
    logic [ROW_W-1:0]   w_row_nxt;
    logic [15:0]        w_din_nxt;
    logic               w_last;
    logic               w_accept_start;

    logic               r_vram_load;
    logic [ADDR_W-1:0]  r_vram_addr;
    logic [15:0]        r_vram_din;
    logic               r_blt_busy;
    logic               r_blt_done;

    assign w_accept_start = (r_state == ST_IDLE) && blt_start;
    assign w_last         = (r_row == r_row1) && (r_col == r_col1);

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_din_nxt   = r_vram_din;
        case (r_state)
            ST_IDLE: begin
                if (blt_start) begin
                    w_col_nxt = blt_col0;
                    w_row_nxt = blt_row0;
                    w_din_nxt = blt_pattern;
                    if ((blt_col0 > blt_col1) || (blt_row0 > blt_row1))
                        w_state_nxt = ST_EMPTY;
                    else if (blt_mode)
                        w_state_nxt = ST_RD;
                    else
                        w_state_nxt = ST_WR;
                end
            end
            ST_RD: begin
                if (!vram_busy)
                    w_state_nxt = ST_CAP;
            end
            ST_CAP: begin
                // Read data belongs to the accepted read of the previous cycle
                w_din_nxt   = vram_dout ^ r_pattern;
                w_state_nxt = ST_WR;
            end
            ST_WR: begin
                if (!vram_busy) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        if (r_col == r_col1) begin
                            w_col_nxt = r_col0;
                            w_row_nxt = r_row + 1'b1;
                        end else begin
                            w_col_nxt = r_col + 1'b1;
                        end
                        w_state_nxt = r_mode ? ST_RD : ST_WR;
                    end
                end
            end
            ST_EMPTY: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= 1'b0;
            r_col0    <= '0;
            r_col1    <= '0;
            r_row1    <= '0;
            r_pattern <= '0;
        end else if (w_accept_start) begin
            r_mode    <= blt_mode;
            r_col0    <= blt_col0;
            r_col1    <= blt_col1;
            r_row1    <= blt_row1;
            r_pattern <= blt_pattern;
        end
    end

    // Outputs are registered images of the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vram_load <= 1'b0;
            r_vram_addr <= '0;
            r_vram_din  <= '0;
            r_blt_busy  <= 1'b0;
            r_blt_done  <= 1'b0;
        end else begin
            r_vram_load <= (w_state_nxt == ST_WR);
            r_vram_addr <= {w_row_nxt, w_col_nxt};
            r_vram_din  <= w_din_nxt;
            r_blt_busy  <= (w_state_nxt == ST_RD) || (w_state_nxt == ST_CAP) ||
                           (w_state_nxt == ST_WR) || (w_state_nxt == ST_EMPTY);
            r_blt_done  <= (w_state_nxt == ST_DONE);
        end
    end

    assign vram_load = r_vram_load;
    assign vram_addr = r_vram_addr;
    assign vram_din  = r_vram_din;
    assign blt_busy  = r_blt_busy;
    assign blt_done  = r_blt_done;

endmodule
`default_nettype wire

// File: tb/tb_vram_blitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vram_blitter
// Brief    : Self-checking bench for vram_blitter with a VRAM model and a
//            write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_blitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        blt_start = 1'b0;
    logic        blt_mode = 1'b0;
    logic [4:0]  blt_col0 = '0;
    logic [4:0]  blt_col1 = '0;
    logic [7:0]  blt_row0 = '0;
    logic [7:0]  blt_row1 = '0;
    logic [15:0] blt_pattern = '0;
    logic        blt_busy;
    logic        blt_done;
    logic        vram_load;
    logic [12:0] vram_addr;
    logic [15:0] vram_din;
    logic        vram_busy = 1'b0;
    logic [15:0] vram_dout = '0;

    always #5 clk = ~clk;

    vram_blitter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .blt_start   (blt_start),
        .blt_mode    (blt_mode),
        .blt_col0    (blt_col0),
        .blt_col1    (blt_col1),
        .blt_row0    (blt_row0),
        .blt_row1    (blt_row1),
        .blt_pattern (blt_pattern),
        .blt_busy    (blt_busy),
        .blt_done    (blt_done),
        .vram_load   (vram_load),
        .vram_addr   (vram_addr),
        .vram_din    (vram_din),
        .vram_busy   (vram_busy),
        .vram_dout   (vram_dout)
    );

    typedef struct {
        logic        mode;
        logic [4:0]  c0;
        logic [4:0]  c1;
        logic [7:0]  r0;
        logic [7:0]  r1;
        logic [15:0] pat;
        bit          stall;
        int          exp_cyc;   // 0: latency not checked (random stalls)
    } vec_t;

    typedef struct {
        logic [12:0] addr;
        logic [15:0] data;
    } wr_t;

    vec_t        vecs[8];
    wr_t         sb[$];
    logic [15:0] mem [0:8191];
    int          checks = 0;
    int          errors = 0;
    int          cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Observe the current cycle's access against the vram_busy about to be
    // applied, then advance one clock (to 1 ns past the rising edge).
    task automatic step();
        wr_t         e;
        logic [15:0] rd_val;
        bit          rd_upd;
        rd_upd = 1'b0;
        rd_val = '0;
        if (vram_load && !vram_busy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%0d data=%h required none", vram_addr, vram_din);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(vram_addr), 32'(e.addr));
                check("wr_data", 32'(vram_din), 32'(e.data));
            end
            mem[vram_addr] = vram_din;
        end else if (!vram_load && !vram_busy) begin
            rd_val = mem[vram_addr];
            rd_upd = 1'b1;
        end
        @(posedge clk);
        #1;
        if (rd_upd) vram_dout = rd_val;
    endtask

    task automatic push_rect(input vec_t v);
        wr_t e;
        for (int r = int'(v.r0); r <= int'(v.r1); r++) begin
            for (int c = int'(v.c0); c <= int'(v.c1); c++) begin
                e.addr = 13'(r * 32 + c);
                e.data = v.mode ? (mem[e.addr] ^ v.pat) : v.pat;
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_done(input int cyc0, input bit stall, input int exp_cyc, output int cyc_out);
        int c;
        c = cyc0;
        while (!blt_done && c < 40000) begin
            check("busy_during_op", 32'(blt_busy), 32'd1);
            vram_busy = stall ? ($urandom_range(0, 3) == 0) : 1'b0;
            step();
            c++;
        end
        vram_busy = 1'b0;
        check("done_seen", 32'(blt_done), 32'd1);
        check("busy_low_at_done", 32'(blt_busy), 32'd0);
        check("load_low_at_done", 32'(vram_load), 32'd0);
        if (exp_cyc > 0) check("done_latency", 32'(c), 32'(exp_cyc));
        check("sb_drained", 32'(sb.size()), 32'd0);
        cyc_out = c;
    endtask

    task automatic start_op(input vec_t v);
        blt_mode    = v.mode;
        blt_col0    = v.c0;
        blt_col1    = v.c1;
        blt_row0    = v.r0;
        blt_row1    = v.r1;
        blt_pattern = v.pat;
        blt_start   = 1'b1;
        step();
        blt_start   = 1'b0;
        blt_mode    = ~v.mode;
        blt_col0    = 5'($urandom);
        blt_col1    = 5'($urandom);
        blt_row0    = 8'($urandom);
        blt_row1    = 8'($urandom);
        blt_pattern = 16'($urandom);
    endtask

    task automatic run(input vec_t v, output int cyc_out);
        push_rect(v);
        start_op(v);
        wait_done(1, v.stall, v.exp_cyc, cyc_out);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 16'(i * 7);
        mem[167] = 16'h00FF;

        vecs[0] = '{1'b1, 5'd7,  5'd7,  8'd5,   8'd5,   16'hFFFF, 1'b0, 4};
        vecs[1] = '{1'b0, 5'd3,  5'd4,  8'd10,  8'd11,  16'hA5A5, 1'b0, 5};
        vecs[2] = '{1'b0, 5'd5,  5'd4,  8'd0,   8'd3,   16'h1234, 1'b0, 2};
        vecs[3] = '{1'b0, 5'd0,  5'd3,  8'd9,   8'd8,   16'h1234, 1'b0, 2};
        vecs[4] = '{1'b1, 5'd2,  5'd5,  8'd100, 8'd102, 16'h1234, 1'b1, 0};
        vecs[5] = '{1'b0, 5'd31, 5'd31, 8'd255, 8'd255, 16'hBEEF, 1'b0, 2};
        vecs[6] = '{1'b1, 5'd0,  5'd31, 8'd0,   8'd1,   16'h5A5A, 1'b0, 193};
        vecs[7] = '{1'b0, 5'd0,  5'd31, 8'd0,   8'd255, 16'h0000, 1'b0, 8193};

        #2 rst_n = 1'b0;
        #1;
        check("rst_load", 32'(vram_load), 32'd0);
        check("rst_addr", 32'(vram_addr), 32'd0);
        check("rst_din",  32'(vram_din),  32'd0);
        check("rst_busy", 32'(blt_busy),  32'd0);
        check("rst_done", 32'(blt_done),  32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run(vecs[i], cyc);
            step();
            check("done_one_cycle", 32'(blt_done), 32'd0);
        end

        // FILL with the second write stalled for two cycles
        push_rect(vecs[1]);
        start_op(vecs[1]);
        vram_busy = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            check("stall_load_held", 32'(vram_load), 32'd1);
            check("stall_addr_held", 32'(vram_addr), 32'd324);
            vram_busy = (k < 2);
            step();
        end
        wait_done(5, 1'b0, 7, cyc);
        step();

        // XOR single word with the read stalled twice and a busy CAP cycle
        mem[167] = 16'h00FF;
        push_rect(vecs[0]);
        start_op(vecs[0]);
        for (int k = 0; k < 2; k++) begin
            check("rd_load_low", 32'(vram_load), 32'd0);
            check("rd_addr_held", 32'(vram_addr), 32'd167);
            vram_busy = 1'b1;
            step();
        end
        vram_busy = 1'b0;
        step();
        vram_busy = 1'b1;
        step();
        check("xor_wr_load", 32'(vram_load), 32'd1);
        check("xor_wr_din", 32'(vram_din), 32'hFF00);
        vram_busy = 1'b0;
        wait_done(5, 1'b0, 6, cyc);

        // Start presented in the DONE cycle must be ignored
        blt_mode = 1'b0; blt_col0 = 5'd0; blt_col1 = 5'd3;
        blt_row0 = 8'd0; blt_row1 = 8'd0; blt_pattern = 16'h7777;
        blt_start = 1'b1;
        step();
        blt_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("done_start_ignored", 32'(blt_busy), 32'd0);
            step();
        end

        // Start while busy is ignored; async reset aborts mid-FILL
        push_rect('{1'b0, 5'd0, 5'd31, 8'd0, 8'd3, 16'h1111, 1'b0, 0});
        start_op('{1'b0, 5'd0, 5'd31, 8'd0, 8'd3, 16'h1111, 1'b0, 0});
        for (int k = 0; k < 10; k++) step();
        blt_mode = 1'b1; blt_col0 = 5'd20; blt_col1 = 5'd21;
        blt_row0 = 8'd200; blt_row1 = 8'd200; blt_pattern = 16'h2222;
        blt_start = 1'b1;
        step();
        blt_start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("pre_rst_busy", 32'(blt_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_load", 32'(vram_load), 32'd0);
        check("async_rst_busy", 32'(blt_busy), 32'd0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_idle", 32'(blt_busy), 32'd0);
        run(vecs[1], cyc);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
